// File: rtl/scope_capture.sv
// Multi-channel triggered capture buffer with pre-trigger history and DONE-state readout.
// Optional sample decimation is compiled in when SCOPE_DECIM_EN is defined.
module scope_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int CH_NUM = 2,
  parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk0,
  input  logic                     sys_rst_n,
  input  logic                     adc_valid,
  input  logic [CH_NUM*DATA_W-1:0] adc_data,
  input  logic                     arm,
  input  logic                     mode_single,
  input  logic [CH_W-1:0]          trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_edge,
  input  logic                     force_trig,
  input  logic [ADDR_W-1:0]        pretrig,
  input  logic [7:0]               decim,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [2:0]               state,
  output logic                     done
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } st_t;

  st_t st, st_nxt;

  logic [CH_W-1:0]   lat_ch;
  logic [DATA_W-1:0] lat_level;
  logic              lat_edge;
  logic [ADDR_W-1:0] lat_pretrig;
  logic [ADDR_W-1:0] wr_ptr, start_ptr, cnt, post_len, rd_phys;
  logic              prev_valid, force_pend;
  logic [DATA_W-1:0] prev_smp, cur_smp;
  logic              accept, wr_en, edge_hit, trig_hit, rd_ok, restart;
  logic [DATA_W-1:0] ch_smp [CH_NUM];
  logic [DATA_W-1:0] mem [CH_NUM][DEPTH];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
    assign ch_smp[g] = adc_data[g*DATA_W +: DATA_W];
  end

  assign rd_ok   = rd_en && (st == S_DONE);
  assign restart = rd_ok && !mode_single && (rd_addr == '1);

`ifdef SCOPE_DECIM_EN
  logic [7:0] lat_decim, decim_cnt;

  assign accept = adc_valid && (decim_cnt == '0);

  always_ff @(posedge clk0 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_decim <= '0;
      decim_cnt <= '0;
    end else if (arm) begin
      lat_decim <= decim;
      decim_cnt <= '0;
    end else if (restart) begin
      decim_cnt <= '0;
    end else if (adc_valid) begin
      decim_cnt <= (decim_cnt == lat_decim) ? '0 : decim_cnt + 8'd1;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign accept       = adc_valid;
`endif

  assign cur_smp  = ch_smp[lat_ch];
  assign wr_en    = accept && (st == S_PRE || st == S_ARMED || st == S_POST);
  assign post_len = '1 - lat_pretrig;
  assign rd_phys  = start_ptr + rd_addr;
  assign edge_hit = prev_valid &&
                    (lat_edge ? (prev_smp >= lat_level && cur_smp <  lat_level)
                              : (prev_smp <  lat_level && cur_smp >= lat_level));
  assign trig_hit = (st == S_ARMED) && accept && (edge_hit || force_pend || force_trig);

  always_ff @(posedge clk0 or negedge sys_rst_n) begin
    if (!sys_rst_n) st <= S_IDLE;
    else            st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (arm) begin
      st_nxt = S_PRE;
    end else begin
      case (st)
        S_IDLE:  st_nxt = S_IDLE;
        S_PRE:   if (lat_pretrig == '0 || (accept && (cnt + ADDR_W'(1)) == lat_pretrig))
                   st_nxt = S_ARMED;
        S_ARMED: if (trig_hit) st_nxt = (post_len == '0) ? S_DONE : S_POST;
        S_POST:  if (accept && cnt == ADDR_W'(1)) st_nxt = S_DONE;
        S_DONE:  if (restart) st_nxt = S_PRE;
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state = st;
    done  = (st == S_DONE);
  end

  // cnt counts pre-trigger samples up in PRE, then remaining post-trigger samples down in POST
  always_ff @(posedge clk0 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_ch      <= '0;
      lat_level   <= '0;
      lat_edge    <= 1'b0;
      lat_pretrig <= '0;
      wr_ptr      <= '0;
      start_ptr   <= '0;
      cnt         <= '0;
      prev_valid  <= 1'b0;
      prev_smp    <= '0;
      force_pend  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (arm) begin
        lat_ch      <= trig_ch;
        lat_level   <= trig_level;
        lat_edge    <= trig_edge;
        lat_pretrig <= pretrig;
        cnt         <= '0;
        prev_valid  <= 1'b0;
        force_pend  <= 1'b0;
      end else if (restart) begin
        cnt         <= '0;
        prev_valid  <= 1'b0;
        force_pend  <= 1'b0;
      end else begin
        if (wr_en) begin
          prev_smp   <= cur_smp;
          prev_valid <= 1'b1;
        end
        case (st)
          S_PRE:   if (accept) cnt <= cnt + ADDR_W'(1);
          S_ARMED: begin
            if (trig_hit) begin
              start_ptr  <= wr_ptr - lat_pretrig;
              cnt        <= post_len;
              force_pend <= 1'b0;
            end else if (force_trig) begin
              force_pend <= 1'b1;
            end
          end
          S_POST:  if (accept) cnt <= cnt - ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < CH_NUM; c++)
        mem[c[CH_W-1:0]][wr_ptr] <= ch_smp[c[CH_W-1:0]];
    end
  end

  always_ff @(posedge clk0 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rd_ch][rd_phys];
    end
  end

endmodule
